rsa_encoder: RTL and testbench
==============================

// Module: rsa_encoder
// PURPOSE
//   RSA encryption engine: computes data_out = data_in^e mod n with the public exponent e.
//   It is the transmit-side counterpart to rsa_decoder and shares its key parameter set.
//   Uses radix-2^logr Montgomery multiplication and left-to-right square-and-multiply.
//   Sits between the plaintext source and the ciphertext sink; one word in flight at a time.
// PARAMETERS
//   n       12'd3551  modulus (odd, n < 2^n_bit)
//   n_bit   12        operand/exponent width; n_bit % logr == 0 required
//   logr    3         Montgomery digit width (radix 2^logr)
//   p       3'd1      -n^-1 mod 2^logr
//   Rmodn   12'd545   2^n_bit mod n (Montgomery one)
//   R2modn  12'd2292  2^(2*n_bit) mod n
//   e       12'd5     public exponent (pairs with d=1373 for the defaults)
// PORTS
//   clk       in   1      system clock, rising edge
//   rst_n     in   1      asynchronous, active-low reset
//   start     in   1      request; level-sampled in IDLE
//   data_in   in   n_bit  plaintext; latched on the accepting edge
//   data_out  out  n_bit  ciphertext; held until the next completion
//   done      out  1      one-cycle completion pulse
// BEHAVIOUR
//   Reset: state=IDLE, data_out=0, done=0, all internal registers 0.
//   FSM: IDLE -> TO_MONT -> {SQR -> [MUL if e[i]]} for i=n_bit-1..0 -> FROM_MONT -> DONE -> WAIT_LOW -> IDLE.
//   IDLE: start=1 latches data_in to M, sets A=Rmodn and i=n_bit-1, then goes to TO_MONT.
//   TO_MONT: Xm = MM(M, R2modn). SQR: A = MM(A, A). MUL: A = MM(A, Xm). FROM_MONT: Y = MM(A, 1).
//   The loop scans all n_bit exponent bits, including leading zeros, so latency depends only on e.
//   DONE: data_out <= Y and done=1 for exactly one cycle.
//   WAIT_LOW: stay until start=0, so a held start does not retrigger. Then return to IDLE.
//   start is ignored outside IDLE. data_in changes after acceptance have no effect.
//   MM(a,b) timing, with k = n_bit/logr:
//     1 issue cycle + k digit cycles + 1 conditional-subtract cycle = k+2 cycles.
//   MM digit step: S = S + a_j*b; q = (S*p) mod 2^logr; S = (S + q*n) >> logr.
//   MM datapath width is n_bit+logr+2 bits with no overflow. After k steps S < 2n; S >= n subtracts n.
//   Latency from the accepting edge to done high is 1 + (2 + n_bit + popcount(e))*(k+2) cycles.
//   Defaults give 97 cycles.
//   data_in >= n is legal and yields (data_in mod n)^e mod n. This holds because data_in < 2^n_bit < 2n.
//   Reset mid-operation aborts immediately with no done pulse; data_out returns to 0.
// STRUCTURE
//   Shared header rsa_defines.vh holds FSM state encodings and the localparam k = n_bit/logr.
//   rsa_decoder includes the same header.
//   Sub-module mont_mul is a radix-2^logr interleaved Montgomery multiplier.
//     Parameters: n, n_bit, logr, p. Ports: clk, rst_n, start, a, b, result, done.
//     Reusable by rsa_decoder.
//   The top level holds the exponent FSM, bit counter i, and registers M/Xm/A/data_out.
// TESTING
//   Defaults, data_in=59, start held high -> done once after 97 cycles, data_out=1469. No second done while start stays 1.
//   data_in=100 -> 492. data_in=2 -> 32. data_in=0 -> 0. data_in=1 -> 1. data_in=3550 -> 3550.
//   data_in=4095 (>= n) -> data_out equals (544^5 mod 3551) from the reference model.
//   Round trip: encode 59 -> 1469; rsa_decoder(e=1373) on 1469 -> 59. Randomise 200 words < n.
//   Change data_in and toggle start mid-run -> result uses the latched word; no extra done.
//   Assert rst_n=0 at cycle 40 of a run -> data_out=0, no done. Next request completes normally.

Source files
------------

// File: rtl/rsa_encoder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rsa_encoder_pkg                                              |
// | Description : Shared key parameters, FSM state types and Montgomery        |
// |               multiplier phase encoding for the RSA encoder.               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package rsa_encoder_pkg;

    // Default key set (modulus 3551 = 53 * 67, e = 5, d = 1373)
    localparam int unsigned DEF_N_BIT  = 12;
    localparam int unsigned DEF_LOGR   = 3;
    localparam logic [11:0] DEF_N      = 12'd3551;
    localparam logic [2:0]  DEF_P      = 3'd1;
    localparam logic [11:0] DEF_RMODN  = 12'd545;
    localparam logic [11:0] DEF_R2MODN = 12'd2292;
    localparam logic [11:0] DEF_E      = 12'd5;

    // Exponentiation controller states
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_TO_MONT   = 3'd1,
        ST_SQR       = 3'd2,
        ST_MUL       = 3'd3,
        ST_FROM_MONT = 3'd4,
        ST_DONE      = 3'd5,
        ST_WAIT_LOW  = 3'd6
    } rsa_state_t;

    // Montgomery multiplier phases: idle/issue, digit loop, final subtract
    typedef enum logic [1:0] {
        MM_IDLE = 2'd0,
        MM_RUN  = 2'd1,
        MM_SUB  = 2'd2
    } mm_phase_t;

endpackage : rsa_encoder_pkg
`default_nettype wire

// File: rtl/rsa_encoder_mont_mul.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rsa_encoder_mont_mul                                         |
// | Description : Radix-2^LOGR interleaved Montgomery multiplier computing     |
// |               a*b*2^-N_BIT mod N. One issue cycle, N_BIT/LOGR digit        |
// |               cycles and one conditional-subtract cycle. done is high      |
// |               during the subtract cycle while result is valid.             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module rsa_encoder_mont_mul
    import rsa_encoder_pkg::*;
#(
    parameter int unsigned      N_BIT = DEF_N_BIT,
    parameter int unsigned      LOGR  = DEF_LOGR,
    parameter logic [N_BIT-1:0] N     = DEF_N,
    parameter logic [LOGR-1:0]  P     = DEF_P
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [N_BIT-1:0] a,
    input  logic [N_BIT-1:0] b,
    output logic [N_BIT-1:0] result,
    output logic             done
);

    localparam int unsigned K  = N_BIT / LOGR;
    // Accumulator headroom: S + a_j*b + q*N never exceeds N_BIT+LOGR+2 bits
    localparam int unsigned SW = N_BIT + LOGR + 2;
    localparam int unsigned CW = $clog2(K + 1);
    localparam logic [CW-1:0] C_LAST = CW'(K - 1);

    mm_phase_t        r_phase;
    logic [N_BIT-1:0] r_a;
    logic [N_BIT-1:0] r_b;
    logic [SW-1:0]    r_s;
    logic [CW-1:0]    r_cnt;

    logic [SW-1:0]    w_n_ext;
    logic [SW-1:0]    w_b_ext;
    logic [SW-1:0]    w_d_ext;
    logic [SW-1:0]    w_s1;
    logic [LOGR-1:0]  w_q;
    logic [SW-1:0]    w_qn;
    logic [SW-1:0]    w_s2;
    logic [SW-1:0]    w_s_next;
    logic [N_BIT-1:0] w_diff;

    // One digit step: add a_j*b, pick q to clear the low digit, add q*N, shift out
    always_comb begin
        w_n_ext  = {{(SW-N_BIT){1'b0}}, N};
        w_b_ext  = {{(SW-N_BIT){1'b0}}, r_b};
        w_d_ext  = {{(SW-LOGR){1'b0}}, r_a[LOGR-1:0]};
        w_s1     = r_s + (w_b_ext * w_d_ext);
        w_q      = w_s1[LOGR-1:0] * P;
        w_qn     = w_n_ext * {{(SW-LOGR){1'b0}}, w_q};
        w_s2     = w_s1 + w_qn;
        w_s_next = w_s2 >> LOGR;
    end

    // Final reduction: after K steps S < 2N, so one subtraction suffices.
    // The true difference fits in N_BIT bits, so a narrow subtract is exact.
    always_comb begin
        w_diff = r_s[N_BIT-1:0] - N;
        result = (r_s >= w_n_ext) ? w_diff : r_s[N_BIT-1:0];
        done   = (r_phase == MM_SUB);
    end

    // Phase sequencer and operand/accumulator registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase <= MM_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_s     <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_phase)
                MM_IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_s     <= '0;
                        r_cnt   <= '0;
                        r_phase <= MM_RUN;
                    end
                end
                MM_RUN: begin
                    r_s   <= w_s_next;
                    r_a   <= r_a >> LOGR;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == C_LAST) begin
                        r_phase <= MM_SUB;
                    end
                end
                MM_SUB: begin
                    r_phase <= MM_IDLE;
                end
                default: begin
                    r_phase <= MM_IDLE;
                end
            endcase
        end
    end

endmodule : rsa_encoder_mont_mul
`default_nettype wire

// File: rtl/rsa_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rsa_encoder                                                  |
// | Description : RSA encryption engine, data_out = data_in^E mod N, using     |
// |               left-to-right square-and-multiply over all N_BIT exponent    |
// |               bits in the Montgomery domain. One word in flight.           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module rsa_encoder
    import rsa_encoder_pkg::*;
#(
    parameter int unsigned      N_BIT  = DEF_N_BIT,
    parameter int unsigned      LOGR   = DEF_LOGR,
    parameter logic [N_BIT-1:0] N      = DEF_N,
    parameter logic [LOGR-1:0]  P      = DEF_P,
    parameter logic [N_BIT-1:0] RMODN  = DEF_RMODN,
    parameter logic [N_BIT-1:0] R2MODN = DEF_R2MODN,
    parameter logic [N_BIT-1:0] E      = DEF_E
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [N_BIT-1:0] data_in,
    output logic [N_BIT-1:0] data_out,
    output logic             done
);

    localparam int unsigned      IW     = $clog2(N_BIT);
    localparam logic [IW-1:0]    C_TOP  = IW'(N_BIT - 1);
    localparam logic [N_BIT-1:0] C_ONE  = {{(N_BIT-1){1'b0}}, 1'b1};

    rsa_state_t       r_state;
    logic [N_BIT-1:0] r_m;
    logic [N_BIT-1:0] r_xm;
    logic [N_BIT-1:0] r_a;
    logic [IW-1:0]    r_i;
    logic             r_issued;

    logic             w_op_state;
    logic             w_mm_start;
    logic [N_BIT-1:0] w_mm_a;
    logic [N_BIT-1:0] w_mm_b;
    logic [N_BIT-1:0] w_mm_result;
    logic             w_mm_done;

    // Operand selection per state; a new multiply is issued once per op state
    always_comb begin
        w_mm_a     = r_a;
        w_mm_b     = r_a;
        w_op_state = 1'b0;
        case (r_state)
            ST_TO_MONT: begin
                w_mm_a     = r_m;
                w_mm_b     = R2MODN;
                w_op_state = 1'b1;
            end
            ST_SQR: begin
                w_op_state = 1'b1;
            end
            ST_MUL: begin
                w_mm_b     = r_xm;
                w_op_state = 1'b1;
            end
            ST_FROM_MONT: begin
                w_mm_b     = C_ONE;
                w_op_state = 1'b1;
            end
            default: begin
                w_op_state = 1'b0;
            end
        endcase
        w_mm_start = w_op_state && !r_issued;
    end

    rsa_encoder_mont_mul #(
        .N_BIT (N_BIT),
        .LOGR  (LOGR),
        .N     (N),
        .P     (P)
    ) u_mont_mul (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (w_mm_start),
        .a      (w_mm_a),
        .b      (w_mm_b),
        .result (w_mm_result),
        .done   (w_mm_done)
    );

    // Exponentiation controller: state, bit counter, Montgomery registers, outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_m      <= '0;
            r_xm     <= '0;
            r_a      <= '0;
            r_i      <= '0;
            r_issued <= 1'b0;
            data_out <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (w_mm_start) begin
                r_issued <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_m     <= data_in;
                        r_a     <= RMODN;
                        r_i     <= C_TOP;
                        r_state <= ST_TO_MONT;
                    end
                end
                ST_TO_MONT: begin
                    if (w_mm_done) begin
                        r_xm     <= w_mm_result;
                        r_issued <= 1'b0;
                        r_state  <= ST_SQR;
                    end
                end
                ST_SQR: begin
                    if (w_mm_done) begin
                        r_a      <= w_mm_result;
                        r_issued <= 1'b0;
                        if (E[r_i]) begin
                            r_state <= ST_MUL;
                        end else if (r_i == '0) begin
                            r_state <= ST_FROM_MONT;
                        end else begin
                            r_i     <= r_i - 1'b1;
                            r_state <= ST_SQR;
                        end
                    end
                end
                ST_MUL: begin
                    if (w_mm_done) begin
                        r_a      <= w_mm_result;
                        r_issued <= 1'b0;
                        if (r_i == '0) begin
                            r_state <= ST_FROM_MONT;
                        end else begin
                            r_i     <= r_i - 1'b1;
                            r_state <= ST_SQR;
                        end
                    end
                end
                ST_FROM_MONT: begin
                    if (w_mm_done) begin
                        r_a      <= w_mm_result;
                        r_issued <= 1'b0;
                        r_state  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    data_out <= r_a;
                    done     <= 1'b1;
                    r_state  <= ST_WAIT_LOW;
                end
                ST_WAIT_LOW: begin
                    // A held request must be released before the next word is taken
                    if (!start) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : rsa_encoder
`default_nettype wire

// File: tb/tb_rsa_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_rsa_encoder                                               |
// | Description : Self-checking bench for rsa_encoder with default key set.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_rsa_encoder;

    localparam int LATENCY = 97;
    localparam int WINDOW  = 120;

    typedef struct {
        logic [11:0] din;
        logic [11:0] exp_out;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [11:0] data_in;
    logic [11:0] data_out;
    logic        done;

    int checks;
    int errors;

    rsa_encoder dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .data_in  (data_in),
        .data_out (data_out),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Plain modular exponentiation, independent of the Montgomery method
    function automatic int modexp(input int unsigned base, input int unsigned ex, input int unsigned m);
        longint unsigned r;
        longint unsigned x;
        r = 1;
        x = base % m;
        for (int k = 0; k < 12; k++) begin
            if (ex[k]) r = (r * x) % m;
            x = (x * x) % m;
        end
        return int'(r);
    endfunction

    // mode 0: normal, 1: hold start high throughout, 2: disturb start/data_in mid-run
    task automatic run_word(input logic [11:0] din, input int mode,
                            output int res, output int lat, output int ndone);
        @(negedge clk);
        data_in = din;
        start   = 1'b1;
        @(posedge clk);
        lat   = -1;
        res   = -1;
        ndone = 0;
        for (int c = 1; c <= WINDOW; c++) begin
            @(posedge clk);
            #1;
            if (done) begin
                ndone++;
                if (lat < 0) begin
                    lat = c;
                    res = int'(data_out);
                end
            end
            if (mode == 2 && c >= 10 && c < 40) begin
                start   = c[0];
                data_in = data_in + 12'd7;
            end
            if (mode != 1 && lat > 0 && c == lat) start = 1'b0;
        end
        if (mode == 2) start = 1'b0;
    endtask

    initial begin
        vec_t vecs[7];
        int   res;
        int   lat;
        int   nd;
        logic [11:0] w;

        vecs[0] = '{12'd59,   12'd1469};
        vecs[1] = '{12'd100,  12'd492};
        vecs[2] = '{12'd2,    12'd32};
        vecs[3] = '{12'd0,    12'd0};
        vecs[4] = '{12'd1,    12'd1};
        vecs[5] = '{12'd3550, 12'd3550};
        vecs[6] = '{12'd4095, 12'd139};

        checks  = 0;
        errors  = 0;
        rst_n   = 1'b0;
        start   = 1'b0;
        data_in = '0;

        #3;
        check("reset_data_out", int'(data_out), 0);
        check("reset_done", int'(done), 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 7; v++) begin
            run_word(vecs[v].din, 0, res, lat, nd);
            check($sformatf("vec%0d_result", v), res, int'(vecs[v].exp_out));
            check($sformatf("vec%0d_latency", v), lat, LATENCY);
            check($sformatf("vec%0d_done_count", v), nd, 1);
        end

        // Held start: one completion only, output held
        run_word(12'd59, 1, res, lat, nd);
        check("hold_result", res, 1469);
        check("hold_latency", lat, LATENCY);
        check("hold_done_count", nd, 1);
        check("hold_data_out", int'(data_out), 1469);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);

        // Input changes and start toggles after acceptance are ignored
        run_word(12'd100, 2, res, lat, nd);
        check("disturb_result", res, 492);
        check("disturb_latency", lat, LATENCY);
        check("disturb_done_count", nd, 1);

        // Reset during a run aborts without completion
        @(negedge clk);
        data_in = 12'd59;
        start   = 1'b1;
        @(posedge clk);
        repeat (40) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b0;
        #1;
        check("midreset_data_out", int'(data_out), 0);
        check("midreset_done", int'(done), 0);
        nd = 0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (done) nd++;
        end
        check("midreset_no_done", nd, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_word(12'd2, 0, res, lat, nd);
        check("post_reset_result", res, 32);
        check("post_reset_latency", lat, LATENCY);

        // Random words below the modulus against the reference model
        for (int r = 0; r < 40; r++) begin
            w = 12'($urandom_range(0, 3550));
            run_word(w, 0, res, lat, nd);
            check($sformatf("rand%0d_din%0d", r, w), res, modexp(w, 5, 3551));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "simulation timeout");
    end

endmodule : tb_rsa_encoder
`default_nettype wire
